// File: rtl/condicionador_botoes_if.sv
// Button-conditioner bus: raw buttons in, conditioned one-hot code plus status out.
// The slave side is the conditioner; the master side is whoever drives the buttons and reads the code.
interface condicionador_botoes_if;
    logic [3:0] botoes_in;
    logic [3:0] botoes;
    logic       jogada_valida;
    logic       erro_multiplo;
    logic [1:0] db_estado;

    modport slave (
        input  botoes_in,
        output botoes,
        output jogada_valida,
        output erro_multiplo,
        output db_estado
    );

    modport master (
        output botoes_in,
        input  botoes,
        input  jogada_valida,
        input  erro_multiplo,
        input  db_estado
    );
endinterface

// File: rtl/condicionador_botoes.sv
// Push-button conditioner: 2-FF synchroniser, per-bit debounce and a small FSM.
// The FSM guarantees botoes is zero or one-hot and that each physical press yields
// exactly one jogada_valida pulse. Multi-button presses are flagged via erro_multiplo.
module condicionador_botoes #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int N_CNT          = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    condicionador_botoes_if.slave bus
);

    localparam logic [1:0] OCIOSO      = 2'd0;
    localparam logic [1:0] PRESSIONADO = 2'd1;
    localparam logic [1:0] INVALIDO    = 2'd2;

    localparam logic [N_CNT-1:0] CNT_LAST = N_CNT'(DEBOUNCE_TICKS - 1);

    logic [3:0]       sync1_reg;
    logic [3:0]       sync2_reg;
    logic [N_CNT-1:0] cnt_reg [4];
    logic             deb_reg [4];
    logic [3:0]       s_deb;

    logic [1:0] state_reg, state_next;
    logic [3:0] code_reg, code_next;
    logic [3:0] botoes_reg, botoes_next;
    logic       jv_reg, jv_next;
    logic       err_reg, err_next;
    logic       one_hot;

    // Two-flop synchroniser for the asynchronous raw buttons.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 4'd0;
            sync2_reg <= 4'd0;
        end else begin
            sync1_reg <= bus.botoes_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            // Accept a level change only after DEBOUNCE_TICKS consecutive mismatching cycles;
            // any agreeing cycle restarts the count so short glitches never get through.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cnt_reg[gi] <= '0;
                    deb_reg[gi] <= 1'b0;
                end else if (sync2_reg[gi] == deb_reg[gi]) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_reg[gi] == CNT_LAST) begin
                    deb_reg[gi] <= sync2_reg[gi];
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_reg[gi] + N_CNT'(1);
                end
            end

            assign s_deb[gi] = deb_reg[gi];
        end
    endgenerate

    assign one_hot = (s_deb != 4'd0) && ((s_deb & (s_deb - 4'd1)) == 4'd0);

    // Next-state and registered-output logic of the press FSM.
    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        botoes_next = botoes_reg;
        jv_next     = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            OCIOSO: begin
                botoes_next = 4'd0;
                if (s_deb == 4'd0) begin
                    state_next = OCIOSO;
                end else if (one_hot) begin
                    state_next  = PRESSIONADO;
                    code_next   = s_deb;
                    botoes_next = s_deb;
                    jv_next     = 1'b1;
                end else begin
                    state_next = INVALIDO;
                    err_next   = 1'b1;
                end
            end
            PRESSIONADO: begin
                if (s_deb == code_reg) begin
                    botoes_next = code_reg;
                end else if (s_deb == 4'd0) begin
                    state_next  = OCIOSO;
                    botoes_next = 4'd0;
                end else begin
                    state_next  = INVALIDO;
                    botoes_next = 4'd0;
                    err_next    = 1'b1;
                end
            end
            INVALIDO: begin
                botoes_next = 4'd0;
                if (s_deb == 4'd0) begin
                    state_next = OCIOSO;
                end else begin
                    err_next = 1'b1;
                end
            end
            default: begin
                // Unused encoding: fall back to idle with everything cleared.
                state_next  = OCIOSO;
                code_next   = 4'd0;
                botoes_next = 4'd0;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= OCIOSO;
            code_reg   <= 4'd0;
            botoes_reg <= 4'd0;
            jv_reg     <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            code_reg   <= code_next;
            botoes_reg <= botoes_next;
            jv_reg     <= jv_next;
            err_reg    <= err_next;
        end
    end

    assign bus.botoes        = botoes_reg;
    assign bus.jogada_valida = jv_reg;
    assign bus.erro_multiplo = err_reg;
    assign bus.db_estado     = state_reg;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Testbench for condicionador_botoes: directed scenarios followed by random button
// activity, all checked cycle by cycle against a window-based reference model.
module tb_condicionador_botoes;

    localparam int DT = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    condicionador_botoes_if bus();

    condicionador_botoes #(.DEBOUNCE_TICKS(DT), .N_CNT(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state: raw samples since reset and the expected outputs.
    logic [3:0] rh [0:8191];
    int         ne;
    logic [3:0] deb_m, code_m, bot_m;
    logic       jv_m;
    int         st_m;

    int vectors = 0;
    int miscompares = 0;
    int jv_cnt;
    logic seen_nz;

    function automatic logic [3:0] ssync_at(int e);
        if (e < 2) return 4'd0;
        return rh[e - 2];
    endfunction

    task automatic model_reset();
        ne = 0; deb_m = 4'd0; code_m = 4'd0; bot_m = 4'd0; jv_m = 1'b0; st_m = 0;
    endtask

    // One rising edge of the model: press FSM on the old debounced vector, then a bit flips
    // when the synchronised input disagreed with it on each of the last DT edges.
    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] new_deb;
        logic [3:0] s;
        logic       stable;
        jv_m = 1'b0;
        if (st_m == 0) begin
            bot_m = 4'd0;
            if ($countones(deb_m) == 1) begin
                st_m = 1; code_m = deb_m; bot_m = deb_m; jv_m = 1'b1;
            end else if ($countones(deb_m) > 1) begin
                st_m = 2;
            end
        end else if (st_m == 1) begin
            if (deb_m == 4'd0) begin
                st_m = 0; bot_m = 4'd0;
            end else if (deb_m != code_m) begin
                st_m = 2; bot_m = 4'd0;
            end
        end else begin
            bot_m = 4'd0;
            if (deb_m == 4'd0) st_m = 0;
        end
        new_deb = deb_m;
        for (int i = 0; i < 4; i++) begin
            stable = 1'b1;
            for (int j = ne - DT + 1; j <= ne; j++) begin
                s = ssync_at(j);
                if (j < 0 || s[i] == deb_m[i]) stable = 1'b0;
            end
            if (stable) new_deb[i] = ~deb_m[i];
        end
        deb_m = new_deb;
        rh[ne] = raw;
        ne++;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of raw input, advance model, compare all outputs at the falling edge.
    task automatic cyc(input logic [3:0] raw);
        bus.botoes_in = raw;
        @(posedge clock);
        model_edge(raw);
        @(negedge clock);
        chk("botoes", bus.botoes, bot_m);
        chk("jogada_valida", {3'd0, bus.jogada_valida}, {3'd0, jv_m});
        chk("erro_multiplo", {3'd0, bus.erro_multiplo}, {3'd0, (st_m == 2)});
        chk("db_estado", {2'd0, bus.db_estado}, 4'(st_m));
        if (bus.jogada_valida) jv_cnt++;
        if (bus.botoes != 4'd0) seen_nz = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_botoes"}, bus.botoes, 4'd0);
        chk({tag, "_jv"}, {3'd0, bus.jogada_valida}, 4'd0);
        chk({tag, "_err"}, {3'd0, bus.erro_multiplo}, 4'd0);
        chk({tag, "_estado"}, {2'd0, bus.db_estado}, 4'd0);
    endtask

    initial begin
        logic [3:0] v;
        int len;
        bus.botoes_in = 4'd0;
        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        reset = 1'b1;
        model_reset();

        // 1: clean press of 0010 then release
        jv_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc(4'b0010);
            if (k == 22) chk("t1_press_early", bus.botoes, 4'b0000);
            if (k == 23) chk("t1_press_lat", bus.botoes, 4'b0010);
            if (k == 23) chk("t1_estado_press", {2'd0, bus.db_estado}, 4'd1);
        end
        for (int k = 1; k <= 40; k++) begin
            cyc(4'b0000);
            if (k == 22) chk("t1_rel_early", bus.botoes, 4'b0010);
            if (k == 23) chk("t1_rel_lat", bus.botoes, 4'b0000);
        end
        chk("t1_jv_count", 4'(jv_cnt), 4'd1);

        // 2: bounce on bit0, last toggle at cycle 28, then held
        jv_cnt = 0;
        for (int c = 1; c <= 90; c++) begin
            v = (c <= 30) ? {3'b000, 1'(((c - 1) / 3) % 2)} : 4'b0001;
            cyc(v);
            if (c == 49) chk("t2_early", bus.botoes, 4'b0000);
            if (c == 50) chk("t2_lat", bus.botoes, 4'b0001);
        end
        chk("t2_jv_count", 4'(jv_cnt), 4'd1);
        for (int k = 0; k < 40; k++) cyc(4'b0000);

        // 3: 15-cycle glitch on bit3
        jv_cnt = 0; seen_nz = 1'b0;
        for (int k = 0; k < 15; k++) cyc(4'b1000);
        for (int k = 0; k < 40; k++) cyc(4'b0000);
        chk("t3_jv_count", 4'(jv_cnt), 4'd0);
        chk("t3_nonzero", {3'd0, seen_nz}, 4'd0);

        // 4: 0100 accepted, 1000 added, partial then full release
        for (int k = 0; k < 30; k++) cyc(4'b0100);
        jv_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc(4'b1100);
            if (k == 23) begin
                chk("t4_botoes", bus.botoes, 4'b0000);
                chk("t4_err", {3'd0, bus.erro_multiplo}, 4'd1);
                chk("t4_estado", {2'd0, bus.db_estado}, 4'd2);
            end
        end
        for (int k = 0; k < 40; k++) cyc(4'b0100);
        chk("t4_partial_estado", {2'd0, bus.db_estado}, 4'd2);
        chk("t4_partial_botoes", bus.botoes, 4'b0000);
        for (int k = 0; k < 40; k++) cyc(4'b0000);
        chk("t4_rel_estado", {2'd0, bus.db_estado}, 4'd0);
        chk("t4_rel_err", {3'd0, bus.erro_multiplo}, 4'd0);
        chk("t4_jv_count", 4'(jv_cnt), 4'd0);

        // 5: asynchronous reset in the middle of a held press
        for (int k = 0; k < 30; k++) cyc(4'b0001);
        chk("t5_held", bus.botoes, 4'b0001);
        reset = 1'b0;
        #1;
        check_zero_outputs("t5_async");
        repeat (2) @(negedge clock);
        check_zero_outputs("t5_hold");
        model_reset();
        reset = 1'b1;
        jv_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc(4'b0001);
            if (k == 22) chk("t5_early", bus.botoes, 4'b0000);
            if (k == 23) chk("t5_lat", bus.botoes, 4'b0001);
        end
        chk("t5_jv_count", 4'(jv_cnt), 4'd1);
        for (int k = 0; k < 40; k++) cyc(4'b0000);

        // 6: two bits appear together
        jv_cnt = 0; seen_nz = 1'b0;
        for (int k = 0; k < 40; k++) cyc(4'b0011);
        chk("t6_estado", {2'd0, bus.db_estado}, 4'd2);
        for (int k = 0; k < 40; k++) cyc(4'b0000);
        chk("t6_jv_count", 4'(jv_cnt), 4'd0);
        chk("t6_nonzero", {3'd0, seen_nz}, 4'd0);
        chk("t6_estado_rel", {2'd0, bus.db_estado}, 4'd0);

        // Random button activity with random hold lengths
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 2))
                0: v = 4'd0;
                1: v = 4'(1 << $urandom_range(0, 3));
                default: v = 4'($urandom_range(0, 15));
            endcase
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) cyc(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
